pipe5_multi_writeback_stage: RTL and testbench
==============================================

Name: pipe5_multi_writeback_stage

Overview:
Parametrised writeback stage that merges NUM_SRC result channels into one integer and one FP register-file write port. Channels include the in-order pipe, multi-cycle divider, FPU and load return. Per cycle it grants at most one integer and one FP write using source-0 priority, round-robin among the other sources, and a starvation override. Granted writes are registered and drive rf_if/frf_if and the forwarding-unit writeback bypass one cycle later.

Parameters:
NUM_SRC, 4, number of result channels (2..8); channel 0 is the in-order pipe.
XLEN, 32, integer data width.
FLEN, 32, FP data width (FLEN <= XLEN; FP data taken from src_data[FLEN-1:0]).
REG_W, 5, register index width.
STARVE_LIMIT, 8, wait cycles after which a non-zero source overrides source 0 (>= 1).

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
src_valid  in  NUM_SRC  result present on channel i
src_ready  out  NUM_SRC  channel i accepted this cycle (combinational)
src_fp  in  NUM_SRC  1 = target FP file, 0 = integer file
src_rd  in  NUM_SRC*REG_W  destination register per channel
src_data  in  NUM_SRC*XLEN  result data per channel
rf_wen  out  1  integer RF write enable
rf_rd  out  REG_W  integer RF index
rf_wdata  out  XLEN  integer RF data
frf_wen  out  1  FP RF write enable
frf_rd  out  REG_W  FP RF index
frf_wdata  out  FLEN  FP RF data
wb_wen  out  1  bypass: equals rf_wen
wb_rd  out  REG_W  bypass: equals rf_rd
wb_data  out  XLEN  bypass: equals rf_wdata
starved  out  NUM_SRC  channel i's wait counter is at STARVE_LIMIT

Behaviour:
- Handshake: transfer on src_valid[i] & src_ready[i]. Sources hold valid, rd, data and fp stable until accepted. src_ready never depends on its own channel's data.
- Each file (int/FP) is arbitrated independently. Requesters are valid channels with matching src_fp.
- Grant order per file:
  1. Any starved requester: lowest index wins.
  2. Otherwise channel 0, if requesting.
  3. Otherwise round-robin over channels 1..NUM_SRC-1, starting at that file's pointer.
- Round-robin pointers (rr_int, rr_fp) take values in 1..NUM_SRC-1. After a non-zero grant, the pointer moves to the granted index + 1, wrapping to 1. Otherwise it holds.
- At most one grant per file per cycle, so at most two src_ready bits are high.
- Wait counters: one per channel, saturating at STARVE_LIMIT.
  - Increment when valid and not granted.
  - Clear when granted or when not valid.
  - Channel 0 has a counter but never needs the override.
- Latency: a grant in cycle t drives rf_*/frf_* from registers in cycle t+1 for exactly one cycle. Each wen is registered as "a grant occurred" for that file.
- x0 rule: an integer grant with rd == 0 is accepted (ready high), but rf_wen = 0 next cycle and rf_rd/rf_wdata are don't-care. f0 is a real register and is written normally.
- Same rd from two channels in one cycle: arbitration order alone decides; the loser writes later (last grant wins). Program order is the upstream scoreboard's responsibility.
- Idle cycles: rf_wen/frf_wen = 0. Data and rd registers hold their last values.
- Reset (RST sampled high):
  - Next cycle: all *_wen = 0, rd/data registers = 0, counters = 0, rr_int = rr_fp = 1, starved = 0.
  - While RST is high, src_ready = 0.
  - Grants in flight when RST asserts are discarded.
  - After RST deasserts, the first possible grant is that same cycle; its write appears the following cycle.

Decomposition:
- Shared package pipe5_wb_pkg: wb_req_t struct {valid, fp, rd, data}, the STARVE_LIMIT default, and the rr-pointer width function clog2(NUM_SRC).
- One sub-module, pipe5_wb_rr_arbiter (parameter NUM_SRC). It owns the pointer and starve-override logic and is instantiated twice (int, FP). Inputs: req vector, starved vector. Outputs: one-hot grant.
- The top level owns the wait counters, output registers and the x0 suppression.

Test Plan:
- Single grant: ch2 valid, fp=0, rd=5, data=0xDEADBEEF at t → src_ready=0b0100 at t; rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF, wb_* identical at t+1; rf_wen=0 at t+2.
- Dual file: ch0 int rd=3 data=0x11 and ch3 FP rd=7 data=0x3F800000 same cycle → ready=0b1001; next cycle rf_wen=1 (rd 3) and frf_wen=1 (rd 7, 0x3F800000).
- Round-robin: ch1, ch2, ch3 all int-valid continuously, ch0 idle, reset pointer → grants over three cycles are ch1, ch2, ch3, then ch1 again.
- Starvation: ch0 and ch1 int-valid every cycle → ch1 waits 8 cycles, starved[1]=1, ch1 granted in cycle 9 over ch0; its counter clears and ch0 resumes.
- x0 write: ch1 int rd=0 data=0xFFFFFFFF → src_ready[1]=1, rf_wen stays 0 next cycle; the same case with fp=1 gives frf_wen=1, frf_rd=0.
- Reset mid-stream: ch2 granted at t and RST=1 at t → t+1: rf_wen=0, src_ready=0 while RST high, rr_int=1; after RST drops, ch2 (still valid) is granted that cycle.

Source files
------------

// File: rtl/pipe5_wb_pkg.sv
// Shared types, defaults and helpers for the pipe5 writeback stage.
// wb_req_t describes one result channel at the default data/register widths.
package pipe5_wb_pkg;

    localparam int WB_NUM_SRC      = 4;
    localparam int WB_XLEN         = 32;
    localparam int WB_FLEN         = 32;
    localparam int WB_REG_W        = 5;
    localparam int WB_STARVE_LIMIT = 8;

    typedef struct packed {
        logic                valid;
        logic                fp;
        logic [WB_REG_W-1:0] rd;
        logic [WB_XLEN-1:0]  data;
    } wb_req_t;

    // Pointer only holds 1..num_src-1, so clog2(num_src) bits suffice (min 1).
    function automatic int rr_ptr_w(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/pipe5_wb_rr_arbiter.sv
// Per-register-file arbiter: starved requesters first, then channel 0,
// then round-robin over channels 1..NUM_SRC-1 from the stored pointer.
module pipe5_wb_rr_arbiter
    import pipe5_wb_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [NUM_SRC-1:0] starved_i,
    output logic [NUM_SRC-1:0] gnt_o
);

    localparam int PTR_W = rr_ptr_w(NUM_SRC);
    localparam int IDX_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        logic             found;
        int               idx;
        logic [IDX_W-1:0] sel;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req_i[i] && starved_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!found && req_i[0]) begin
            gnt_o[0] = 1'b1;
            found    = 1'b1;
        end
        // Walk 1..NUM_SRC-1 starting at the pointer, skipping channel 0 on wrap.
        for (int k = 0; k < NUM_SRC - 1; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - (NUM_SRC - 1);
            sel = IDX_W'(idx);
            if (!found && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 1; i < NUM_SRC; i++) begin
            if (gnt_o[i]) ptr_d = (i == NUM_SRC - 1) ? PTR_W'(1) : PTR_W'(i + 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= PTR_W'(1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pipe5_multi_writeback_stage.sv
// Writeback stage merging NUM_SRC result channels into one integer and one
// FP register-file write port, with per-channel starvation counters.
module pipe5_multi_writeback_stage
    import pipe5_wb_pkg::*;
#(
    parameter int NUM_SRC      = WB_NUM_SRC,
    parameter int XLEN         = WB_XLEN,
    parameter int FLEN         = WB_FLEN,
    parameter int REG_W        = WB_REG_W,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC-1:0]       src_fp,
    input  logic [NUM_SRC*REG_W-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]  src_data,
    output logic                     rf_wen,
    output logic [REG_W-1:0]         rf_rd,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     frf_wen,
    output logic [REG_W-1:0]         frf_rd,
    output logic [FLEN-1:0]          frf_wdata,
    output logic                     wb_wen,
    output logic [REG_W-1:0]         wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [NUM_SRC-1:0]       starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_SRC-1:0] req_int, req_fp, gnt_int, gnt_fp;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    logic [REG_W-1:0]   int_rd, fp_rd;
    logic [XLEN-1:0]    int_data;
    logic [FLEN-1:0]    fp_data;

    logic               rf_wen_q, frf_wen_q;
    logic [REG_W-1:0]   rf_rd_q, frf_rd_q;
    logic [XLEN-1:0]    rf_wdata_q;
    logic [FLEN-1:0]    frf_wdata_q;

    // Masking requests during reset keeps ready low and the pointers frozen.
    assign req_int   = src_valid & ~src_fp & {NUM_SRC{~RST}};
    assign req_fp    = src_valid &  src_fp & {NUM_SRC{~RST}};
    assign src_ready = gnt_int | gnt_fp;

    pipe5_wb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb_int (
        .clk_i(CLK), .rst_i(RST), .req_i(req_int), .starved_i(starved), .gnt_o(gnt_int)
    );

    pipe5_wb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb_fp (
        .clk_i(CLK), .rst_i(RST), .req_i(req_fp), .starved_i(starved), .gnt_o(gnt_fp)
    );

    always_comb begin
        int_rd   = '0;
        int_data = '0;
        fp_rd    = '0;
        fp_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_int[i]) begin
                int_rd   = src_rd[i*REG_W +: REG_W];
                int_data = src_data[i*XLEN +: XLEN];
            end
            if (gnt_fp[i]) begin
                fp_rd   = src_rd[i*REG_W +: REG_W];
                fp_data = src_data[i*XLEN +: FLEN];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            starved[i] = (cnt_q[i] == CNT_W'(STARVE_LIMIT));
            if (!src_valid[i] || src_ready[i]) cnt_d[i] = '0;
            else if (starved[i])               cnt_d[i] = cnt_q[i];
            else                               cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    // Integer writes to x0 are accepted but never reach the register file.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_wen_q    <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
            frf_wen_q   <= 1'b0;
            frf_rd_q    <= '0;
            frf_wdata_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else begin
            rf_wen_q  <= (|gnt_int) && (int_rd != '0);
            frf_wen_q <= |gnt_fp;
            if (|gnt_int) begin
                rf_rd_q    <= int_rd;
                rf_wdata_q <= int_data;
            end
            if (|gnt_fp) begin
                frf_rd_q    <= fp_rd;
                frf_wdata_q <= fp_data;
            end
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rf_wen    = rf_wen_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wdata  = rf_wdata_q;
    assign frf_wen   = frf_wen_q;
    assign frf_rd    = frf_rd_q;
    assign frf_wdata = frf_wdata_q;
    assign wb_wen    = rf_wen_q;
    assign wb_rd     = rf_rd_q;
    assign wb_data   = rf_wdata_q;

endmodule

// File: tb/tb_pipe5_multi_writeback_stage.sv
// Directed self-checking bench for pipe5_multi_writeback_stage at default
// parameters; expected values are hand-computed per scenario.
module tb_pipe5_multi_writeback_stage;
    import pipe5_wb_pkg::*;

    localparam int N = WB_NUM_SRC;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [N-1:0]           src_valid, src_ready, src_fp, starved;
    logic [N*WB_REG_W-1:0]  src_rd;
    logic [N*WB_XLEN-1:0]   src_data;
    logic                   rf_wen, frf_wen, wb_wen;
    logic [WB_REG_W-1:0]    rf_rd, frf_rd, wb_rd;
    logic [WB_XLEN-1:0]     rf_wdata, wb_data;
    logic [WB_FLEN-1:0]     frf_wdata;

    int checks = 0;
    int fails  = 0;

    pipe5_multi_writeback_stage dut (
        .CLK(CLK), .RST(RST),
        .src_valid(src_valid), .src_ready(src_ready), .src_fp(src_fp),
        .src_rd(src_rd), .src_data(src_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .frf_wen(frf_wen), .frf_rd(frf_rd), .frf_wdata(frf_wdata),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .starved(starved)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_req_t mk(input logic fp, input logic [WB_REG_W-1:0] rd, input logic [WB_XLEN-1:0] data);
        wb_req_t r;
        r.valid = 1'b1;
        r.fp    = fp;
        r.rd    = rd;
        r.data  = data;
        return r;
    endfunction

    task automatic applyStimulus(input int ch, input wb_req_t r);
        src_valid[ch] = r.valid;
        src_fp[ch]    = r.fp;
        src_rd[ch*WB_REG_W +: WB_REG_W] = r.rd;
        src_data[ch*WB_XLEN +: WB_XLEN] = r.data;
    endtask

    task automatic clearInputs();
        src_valid = '0;
        src_fp    = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        src_valid = '0; src_fp = '0; src_rd = '0; src_data = '0;
        tick();
        // Reset: no ready while held, everything zero afterwards.
        applyStimulus(0, mk(1'b0, 5'd1, 32'h1));
        #1 checkOutput("reset ready", src_ready, 4'b0000);
        tick();
        checkOutput("reset rf_wen", rf_wen, 0);
        checkOutput("reset frf_wen", frf_wen, 0);
        checkOutput("reset rf_rd", rf_rd, 0);
        checkOutput("reset rf_wdata", rf_wdata, 0);
        checkOutput("reset starved", starved, 0);
        clearInputs();
        RST = 1'b0;

        $display("[TB] single grant");
        applyStimulus(2, mk(1'b0, 5'd5, 32'hDEADBEEF));
        #1 checkOutput("single ready", src_ready, 4'b0100);
        tick(); clearInputs();
        checkOutput("single rf_wen", rf_wen, 1);
        checkOutput("single rf_rd", rf_rd, 5);
        checkOutput("single rf_wdata", rf_wdata, 32'hDEADBEEF);
        checkOutput("single wb_wen", wb_wen, 1);
        checkOutput("single wb_rd", wb_rd, 5);
        checkOutput("single wb_data", wb_data, 32'hDEADBEEF);
        checkOutput("single frf_wen", frf_wen, 0);
        tick();
        checkOutput("single idle rf_wen", rf_wen, 0);
        checkOutput("single hold rf_rd", rf_rd, 5);

        $display("[TB] dual file");
        applyStimulus(0, mk(1'b0, 5'd3, 32'h11));
        applyStimulus(3, mk(1'b1, 5'd7, 32'h3F800000));
        #1 checkOutput("dual ready", src_ready, 4'b1001);
        tick(); clearInputs();
        checkOutput("dual rf_wen", rf_wen, 1);
        checkOutput("dual rf_rd", rf_rd, 3);
        checkOutput("dual rf_wdata", rf_wdata, 32'h11);
        checkOutput("dual frf_wen", frf_wen, 1);
        checkOutput("dual frf_rd", frf_rd, 7);
        checkOutput("dual frf_wdata", frf_wdata, 32'h3F800000);
        tick();

        $display("[TB] round robin");
        RST = 1'b1; tick(); RST = 1'b0;
        applyStimulus(1, mk(1'b0, 5'd1, 32'hA1));
        applyStimulus(2, mk(1'b0, 5'd2, 32'hA2));
        applyStimulus(3, mk(1'b0, 5'd3, 32'hA3));
        #1 checkOutput("rr ready c0", src_ready, 4'b0010);
        tick();
        checkOutput("rr rf_rd c0", rf_rd, 1);
        checkOutput("rr ready c1", src_ready, 4'b0100);
        tick();
        checkOutput("rr rf_rd c1", rf_rd, 2);
        checkOutput("rr ready c2", src_ready, 4'b1000);
        tick();
        checkOutput("rr rf_rd c2", rf_rd, 3);
        checkOutput("rr rf_wdata c2", rf_wdata, 32'hA3);
        checkOutput("rr ready c3", src_ready, 4'b0010);
        tick(); clearInputs();
        checkOutput("rr rf_rd c3", rf_rd, 1);
        tick();
        checkOutput("rr idle rf_wen", rf_wen, 0);

        $display("[TB] starvation");
        applyStimulus(0, mk(1'b0, 5'd10, 32'h100));
        applyStimulus(1, mk(1'b0, 5'd11, 32'h111));
        for (int c = 1; c <= 8; c++) begin
            #1 checkOutput($sformatf("starve ch0 wins c%0d", c), src_ready, 4'b0001);
            tick();
        end
        #1 checkOutput("starve flag", starved, 4'b0010);
        checkOutput("starve override ready", src_ready, 4'b0010);
        tick();
        checkOutput("starve rf_rd", rf_rd, 11);
        checkOutput("starve rf_wdata", rf_wdata, 32'h111);
        checkOutput("starve cleared", starved, 4'b0000);
        checkOutput("starve ch0 resumes", src_ready, 4'b0001);
        clearInputs();
        tick();

        $display("[TB] x0 / f0");
        applyStimulus(1, mk(1'b0, 5'd0, 32'hFFFFFFFF));
        #1 checkOutput("x0 ready", src_ready, 4'b0010);
        tick(); clearInputs();
        checkOutput("x0 rf_wen", rf_wen, 0);
        checkOutput("x0 wb_wen", wb_wen, 0);
        applyStimulus(1, mk(1'b1, 5'd0, 32'hFFFFFFFF));
        #1 checkOutput("f0 ready", src_ready, 4'b0010);
        tick(); clearInputs();
        checkOutput("f0 frf_wen", frf_wen, 1);
        checkOutput("f0 frf_rd", frf_rd, 0);
        checkOutput("f0 frf_wdata", frf_wdata, 32'hFFFFFFFF);
        tick();

        $display("[TB] reset mid-stream");
        applyStimulus(2, mk(1'b0, 5'd9, 32'h99));
        RST = 1'b1;
        #1 checkOutput("midrst ready t", src_ready, 4'b0000);
        tick();
        checkOutput("midrst rf_wen", rf_wen, 0);
        checkOutput("midrst rf_rd", rf_rd, 0);
        checkOutput("midrst frf_rd", frf_rd, 0);
        checkOutput("midrst ready t+1", src_ready, 4'b0000);
        RST = 1'b0;
        #1 checkOutput("midrst regrant ready", src_ready, 4'b0100);
        tick(); clearInputs();
        checkOutput("midrst regrant rf_wen", rf_wen, 1);
        checkOutput("midrst regrant rf_rd", rf_rd, 9);
        checkOutput("midrst regrant rf_wdata", rf_wdata, 32'h99);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
